// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
//   Shared definitions for the Morse playback path and sequence storage:
//   symbol codes, message geometry, per-symbol durations in Morse units and
//   the playback FSM state encoding.
// -----------------------------------------------------------------------------
package morse_pkg;

   localparam int unsigned SYM_W       = 2;
   localparam int unsigned SEQ_SYMBOLS = 80;
   localparam int unsigned SEQ_W       = 160;

   typedef logic [SYM_W-1:0] sym_t;

   localparam sym_t SYM_DOT   = 2'b00;
   localparam sym_t SYM_DASH  = 2'b01;
   localparam sym_t SYM_LSEP  = 2'b10;
   localparam sym_t SYM_EMPTY = 2'b11;

   // Durations in Morse units (2-bit unit count fed to the unit timer)
   localparam logic [1:0] DOT_UNITS  = 2'd1;
   localparam logic [1:0] DASH_UNITS = 2'd3;
   localparam logic [1:0] LSEP_UNITS = 2'd2;
   localparam logic [1:0] GAP_UNITS  = 2'd1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_MARK,
      ST_GAP
   } state_t;

   // Timed length of a symbol's first segment (mark for dot/dash, silence for
   // a letter separator). Empty symbols are never timed.
   function automatic logic [1:0] sym_units(input sym_t s);
      logic [1:0] u;
      case (s)
         SYM_DOT:  u = DOT_UNITS;
         SYM_DASH: u = DASH_UNITS;
         SYM_LSEP: u = LSEP_UNITS;
         default:  u = 2'd0;
      endcase
      return u;
   endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// -----------------------------------------------------------------------------
// morse_unit_timer
//   Down-counter measuring whole Morse units. A load of n units times exactly
//   n*UNIT_CYCLES cycles; expire is high during the last of those cycles.
//   Ports:
//     clk     in   system clock
//     reset   in   synchronous active-high clear
//     load    in   start a new interval (takes priority over counting)
//     units   in   interval length in Morse units (1..3)
//     busy    out  an interval is being timed
//     expire  out  final cycle of the current interval
// -----------------------------------------------------------------------------
module morse_unit_timer #(
   parameter int unsigned UNIT_CYCLES = 5_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [1:0] units,
   output logic       busy,
   output logic       expire
);

   localparam int unsigned TW = $clog2(3*UNIT_CYCLES+1);
   localparam logic [TW-1:0] UNIT_T = TW'(UNIT_CYCLES);

   logic [TW-1:0] count;
   logic [TW-1:0] load_val;

   always_comb begin
      load_val = TW'(units) * UNIT_T - TW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         busy  <= 1'b0;
      end else if (load) begin
         count <= load_val;
         busy  <= 1'b1;
      end else if (busy) begin
         if (count == '0) begin
            busy <= 1'b0;
         end else begin
            count <= count - TW'(1);
         end
      end
   end

   assign expire = busy && (count == '0);

endmodule

// File: rtl/morse_playback_scheduler.sv
// -----------------------------------------------------------------------------
// morse_playback_scheduler
//   Plays a snapshot of the stored message as timed on/off keying.
//   Ports:
//     clk         in   system clock
//     reset       in   synchronous active-high reset
//     start       in   begin playback (only honoured when idle)
//     abort       in   stop playback at once; beats start
//     i_sequence  in   message, symbol k at [SEQ_W-1-SYM_W*k -: SYM_W]
//     o_tone      out  keying output, 1 = mark
//     o_busy      out  playback in progress
//     o_done      out  one-cycle pulse on normal completion
//     o_sym_idx   out  index of the symbol being played
// -----------------------------------------------------------------------------
module morse_playback_scheduler #(
   parameter int unsigned UNIT_CYCLES = 5_000_000,
   parameter int unsigned SEQ_SYMBOLS = morse_pkg::SEQ_SYMBOLS,
   parameter int unsigned SYM_W       = morse_pkg::SYM_W
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         abort,
   input  logic [SEQ_SYMBOLS*SYM_W-1:0] i_sequence,
   output logic                         o_tone,
   output logic                         o_busy,
   output logic                         o_done,
   output logic [6:0]                   o_sym_idx
);

   import morse_pkg::*;

   localparam int unsigned SNAP_W   = SEQ_SYMBOLS * SYM_W;
   localparam logic [6:0]  LAST_IDX = 7'(SEQ_SYMBOLS - 1);

   state_t            state;
   state_t            state_nxt;
   logic [SNAP_W-1:0] snap;
   sym_t              cur_sym;
   logic              tone_nxt;
   logic              busy_nxt;
   logic              done_nxt;
   logic              t_load;
   logic [1:0]        t_units;
   logic              t_busy;
   logic              t_expire;
   logic              seg_end;
   logic              accept;
   logic              advance;

   morse_unit_timer #(
      .UNIT_CYCLES(UNIT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (t_load),
      .units  (t_units),
      .busy   (t_busy),
      .expire (t_expire)
   );

   // The current symbol is always at the top of the snapshot.
   assign cur_sym = snap[SNAP_W-1 -: SYM_W];

   // An idle timer while timing a segment also ends it, so the FSM can never
   // wait forever on a timer that was not loaded.
   assign seg_end = t_expire || !t_busy;

   assign accept  = !abort && (state == ST_IDLE) && start;
   assign advance = !abort && (state == ST_GAP) && seg_end;

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         o_tone <= 1'b0;
         o_busy <= 1'b0;
         o_done <= 1'b0;
      end else begin
         state  <= state_nxt;
         o_tone <= tone_nxt;
         o_busy <= busy_nxt;
         o_done <= done_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (start) state_nxt = ST_FETCH;
            ST_FETCH: begin
               case (cur_sym)
                  SYM_DOT, SYM_DASH: state_nxt = ST_MARK;
                  SYM_LSEP:          state_nxt = ST_GAP;
                  default:           state_nxt = ST_IDLE;
               endcase
            end
            ST_MARK:  if (seg_end) state_nxt = ST_GAP;
            ST_GAP:   if (seg_end) state_nxt = ST_FETCH;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   // Output / timer-control logic
   always_comb begin
      tone_nxt = (state_nxt == ST_MARK);
      busy_nxt = (state_nxt != ST_IDLE);
      done_nxt = 1'b0;
      t_load   = 1'b0;
      t_units  = GAP_UNITS;
      if (!abort) begin
         case (state)
            ST_FETCH: begin
               if (cur_sym == SYM_EMPTY) begin
                  done_nxt = 1'b1;
               end else begin
                  t_load  = 1'b1;
                  t_units = sym_units(cur_sym);
               end
            end
            ST_MARK: begin
               if (seg_end) begin
                  t_load  = 1'b1;
                  t_units = GAP_UNITS;
               end
            end
            default: ;
         endcase
      end
   end

   // Symbol index; holds at the last slot so it never presents SEQ_SYMBOLS.
   always_ff @(posedge clk) begin
      if (reset || abort || accept) begin
         o_sym_idx <= '0;
      end else if (advance && (o_sym_idx != LAST_IDX)) begin
         o_sym_idx <= o_sym_idx + 7'd1;
      end
   end

   // Snapshot survives reset. Shifting in EMPTY codes makes the slot after the
   // last one read as end-of-message, so a full message ends without an
   // explicit index compare.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (accept) begin
            snap <= i_sequence;
         end else if (advance) begin
            snap <= {snap[SNAP_W-SYM_W-1:0], {SYM_W{1'b1}}};
         end
      end
   end

endmodule

// File: tb/tb_morse_playback_scheduler.sv
module tb_morse_playback_scheduler;

   localparam int unsigned U = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         abort;
   logic [159:0] seq;
   logic         tone;
   logic         busy;
   logic         done;
   logic [6:0]   sym_idx;

   always #5 clk = ~clk;

   morse_playback_scheduler #(
      .UNIT_CYCLES(U)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .i_sequence (seq),
      .o_tone     (tone),
      .o_busy     (busy),
      .o_done     (done),
      .o_sym_idx  (sym_idx)
   );

   typedef struct packed {
      logic       tone;
      logic       busy;
      logic       done;
      logic [6:0] idx;
   } obs_t;

   obs_t         exp_q[$];
   int           checks = 0;
   int           errors = 0;
   int           rises;
   int           dones;
   logic [159:0] msg;

   function automatic obs_t observe();
      obs_t o;
      o = {tone, busy, done, sym_idx};
      return o;
   endfunction

   task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic t, input logic b, input logic d, input int k);
      obs_t o;
      o = {t, b, d, 7'(k)};
      exp_q.push_back(o);
   endtask

   task automatic set_sym(input int k, input logic [1:0] c);
      msg[159-2*k -: 2] = c;
   endtask

   // Per-cycle expected outputs, first entry = cycle after the start edge.
   task automatic model(input logic [159:0] m);
      logic [1:0] s;
      int         mark;
      int         quiet;
      exp_q.delete();
      for (int k = 0; k < 80; k++) begin
         s = m[159-2*k -: 2];
         push(1'b0, 1'b1, 1'b0, k);
         if (s == 2'b11) begin
            push(1'b0, 1'b0, 1'b1, k);
            push(1'b0, 1'b0, 1'b0, k);
            return;
         end
         mark  = (s == 2'b00) ? 1 : (s == 2'b01) ? 3 : 0;
         quiet = (s == 2'b10) ? 2 : 1;
         repeat (mark * U)  push(1'b1, 1'b1, 1'b0, k);
         repeat (quiet * U) push(1'b0, 1'b1, 1'b0, k);
      end
      push(1'b0, 1'b1, 1'b0, 79);
      push(1'b0, 1'b0, 1'b1, 79);
      push(1'b0, 1'b0, 1'b0, 79);
   endtask

   // Start playback of msg and compare up to max_cycles scoreboard entries.
   // At cycle inject_at (>0) a stray start and a new i_sequence are applied.
   task automatic play(input string tag, input int max_cycles, input int inject_at);
      int   n;
      logic prev;
      model(msg);
      @(negedge clk);
      seq   = msg;
      start = 1'b1;
      n     = (max_cycles < exp_q.size()) ? max_cycles : exp_q.size();
      rises = 0;
      dones = 0;
      prev  = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == 0) start = 1'b0;
         if (i == inject_at) begin
            start = 1'b1;
            seq   = {$urandom, $urandom, $urandom, $urandom, $urandom};
         end
         if (inject_at > 0 && i == inject_at + 1) start = 1'b0;
         if (tone && !prev) rises++;
         prev = tone;
         if (done) dones++;
         check(tag, observe(), exp_q.pop_front());
      end
      exp_q.delete();
   endtask

   task automatic check_idle(input string tag, input int n);
      repeat (n) begin
         @(negedge clk);
         check(tag, observe(), 10'd0);
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      seq   = '0;
      msg   = '1;
      repeat (2) @(negedge clk);
      check("reset_state", observe(), 10'd0);
      reset = 1'b0;
      check_idle("idle_after_reset", 2);

      // 1: reset in the middle of a dash
      msg = '1;
      set_sym(0, 2'b01);
      play("t1_dash", 8, -1);
      reset = 1'b1;
      check_idle("t1_reset", 3);
      reset = 1'b0;
      check_idle("t1_released", 2);

      // 2: single dot, plays from idx 0 after the reset
      msg = '1;
      set_sym(0, 2'b00);
      play("t2_dot", 1000, -1);
      check("t2_rises", 10'(rises), 10'd1);
      check("t2_dones", 10'(dones), 10'd1);

      // 3: dash, separator, dot
      msg = '1;
      set_sym(0, 2'b01);
      set_sym(1, 2'b10);
      set_sym(2, 2'b00);
      play("t3_mix", 1000, -1);
      check("t3_rises", 10'(rises), 10'd2);
      check("t3_dones", 10'(dones), 10'd1);

      // 6b: same message, stray start and new i_sequence mid-play
      play("t6_restart", 1000, 10);
      check("t6_restart_rises", 10'(rises), 10'd2);
      check("t6_restart_dones", 10'(dones), 10'd1);

      // 4: full message of dots
      msg = '0;
      play("t4_80dots", 2000, -1);
      check("t4_rises", 10'(rises), 10'd80);
      check("t4_dones", 10'(dones), 10'd1);

      // 6a: empty message
      msg = '1;
      play("t6_empty", 1000, -1);
      check("t6_empty_rises", 10'(rises), 10'd0);
      check("t6_empty_dones", 10'(dones), 10'd1);

      // 5: abort during the 6th cycle of a dash
      msg = '1;
      set_sym(0, 2'b01);
      play("t5_dash", 7, -1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t5_abort", observe(), 10'd0);
      check_idle("t5_after_abort", 6);

      // 5: start and abort together while idle
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("t5_start_abort", observe(), 10'd0);
      check_idle("t5_stays_idle", 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
